multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ctrl_pkg.sv | 65 ++++++
 rtl/opcode_class_decode.sv | 26 ++
 rtl/multicycle_control.sv | 159 +++++++++++++++
 tb/tb_multicycle_control.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcode classes,
// opcode constants and the datapath select field values.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_R      = 3'd1,
    CLS_I      = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JAL    = 3'd6,
    CLS_JALR   = 3'd7
  } op_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_out_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Maps a 7-bit RV32 major opcode to its controller class; unknown opcodes
// report CLS_NONE with o_legal low.
module opcode_class_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output op_class_t  o_class,
  output logic       o_legal
);

  always_comb begin
    o_class = CLS_NONE;
    o_legal = 1'b1;
    case (i_opcode)
      OP_R:      o_class = CLS_R;
      OP_I:      o_class = CLS_I;
      OP_LOAD:   o_class = CLS_LOAD;
      OP_STORE:  o_class = CLS_STORE;
      OP_BRANCH: o_class = CLS_BRANCH;
      OP_JAL:    o_class = CLS_JAL;
      OP_JALR:   o_class = CLS_JALR;
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: FETCH, DECODE, EXEC, MEM, WB with memory waits
// and an opcode class latched in DECODE so later opcode changes are ignored.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [2:0] dbg_state
);

  state_t    r_state;
  state_t    w_next;
  op_class_t r_class;
  op_class_t w_dec_class;
  logic      w_dec_legal;
  ctrl_out_t w_out;
  ctrl_out_t w_gated;

  opcode_class_decode u_decode (
    .i_opcode (opcode),
    .o_class  (w_dec_class),
    .o_legal  (w_dec_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_class <= CLS_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_class <= w_dec_class;
    end
  end

  // Memory handshake: a request (mem_read/mem_write) stays high every cycle
  // until the cycle mem_ready is high; that cycle completes the transfer.
  always_comb begin
    w_next = r_state;
    w_out  = '0;
    case (r_state)
      S_FETCH: begin
        w_out.mem_read  = 1'b1;
        w_out.alu_src_b = SRCB_FOUR;
        w_out.alu_op    = ALU_ADD;
        if (mem_ready) begin
          w_out.ir_write = 1'b1;
          w_out.pc_write = 1'b1;
          w_out.pc_src   = PC_PLUS4;
          w_next         = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_dec_legal) begin
          w_next = S_EXEC;
        end else begin
          w_out.illegal_op = 1'b1;
          w_next           = S_FETCH;
        end
      end
      S_EXEC: begin
        w_next = S_FETCH;
        case (r_class)
          CLS_R, CLS_I: begin
            w_out.alu_src_a = 1'b1;
            w_out.alu_src_b = (r_class == CLS_R) ? SRCB_RS2 : SRCB_IMM;
            w_out.alu_op    = (r_class == CLS_R) ? ALU_RTYPE : ALU_ITYPE;
            w_next          = S_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            w_out.alu_src_a = 1'b1;
            w_out.alu_src_b = SRCB_IMM;
            w_out.alu_op    = ALU_ADD;
            w_next          = S_MEM;
          end
          CLS_BRANCH: begin
            w_out.alu_src_a     = 1'b1;
            w_out.alu_src_b     = SRCB_RS2;
            w_out.alu_op        = ALU_SUB;
            w_out.pc_write_cond = 1'b1;
            w_out.pc_src        = PC_TARGET;
            w_out.instr_done    = 1'b1;
          end
          CLS_JAL: begin
            w_out.reg_write  = 1'b1;
            w_out.mem_to_reg = WB_PC4;
            w_out.pc_write   = 1'b1;
            w_out.pc_src     = PC_TARGET;
            w_out.instr_done = 1'b1;
          end
          CLS_JALR: begin
            w_out.reg_write  = 1'b1;
            w_out.mem_to_reg = WB_PC4;
            w_out.pc_write   = 1'b1;
            w_out.pc_src     = PC_JALR;
            w_out.alu_src_a  = 1'b1;
            w_out.alu_src_b  = SRCB_IMM;
            w_out.alu_op     = ALU_ADD;
            w_out.instr_done = 1'b1;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (r_class == CLS_STORE) begin
          w_out.mem_write = 1'b1;
          if (mem_ready) begin
            w_out.instr_done = 1'b1;
            w_next           = S_FETCH;
          end
        end else if (r_class == CLS_LOAD) begin
          w_out.mem_read = 1'b1;
          if (mem_ready) w_next = S_WB;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_WB: begin
        w_out.reg_write  = 1'b1;
        w_out.mem_to_reg = (r_class == CLS_LOAD) ? WB_MEM : WB_ALU;
        w_out.instr_done = 1'b1;
        w_next           = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset forces every output low combinationally, even in the FETCH state.
  assign w_gated       = reset ? '0 : w_out;
  assign mem_read      = w_gated.mem_read;
  assign mem_write     = w_gated.mem_write;
  assign ir_write      = w_gated.ir_write;
  assign pc_write      = w_gated.pc_write;
  assign pc_write_cond = w_gated.pc_write_cond;
  assign pc_src        = w_gated.pc_src;
  assign alu_src_a     = w_gated.alu_src_a;
  assign alu_src_b     = w_gated.alu_src_b;
  assign alu_op        = w_gated.alu_op;
  assign mem_to_reg    = w_gated.mem_to_reg;
  assign reg_write     = w_gated.reg_write;
  assign instr_done    = w_gated.instr_done;
  assign illegal_op    = w_gated.illegal_op;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into a per-cycle
// list of expected control words, inputs and mem_ready values.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_read, mem_write, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_src_b, alu_op, mem_to_reg;
  logic       alu_src_a, reg_write, instr_done, illegal_op;
  logic [2:0] dbg_state;

  multicycle_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Observed control word, field order:
  // rd wr irw pcw pcc pcs[2] asa asb[2] aop[2] m2r[2] rw done ill
  logic [16:0] got;
  assign got = {mem_read, mem_write, ir_write, pc_write, pc_write_cond, pc_src,
                alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write, instr_done,
                illegal_op};

  localparam logic [16:0] B_RD   = 17'h10000;
  localparam logic [16:0] B_WR   = 17'h08000;
  localparam logic [16:0] B_IRW  = 17'h04000;
  localparam logic [16:0] B_PCW  = 17'h02000;
  localparam logic [16:0] B_PCC  = 17'h01000;
  localparam logic [16:0] B_ASA  = 17'h00200;
  localparam logic [16:0] B_RW   = 17'h00004;
  localparam logic [16:0] B_DONE = 17'h00002;
  localparam logic [16:0] B_ILL  = 17'h00001;

  function automatic logic [16:0] f_pcs(input logic [1:0] v); return {5'b0, v, 10'b0};  endfunction
  function automatic logic [16:0] f_asb(input logic [1:0] v); return {8'b0, v, 7'b0};   endfunction
  function automatic logic [16:0] f_aop(input logic [1:0] v); return {10'b0, v, 5'b0};  endfunction
  function automatic logic [16:0] f_m2r(input logic [1:0] v); return {12'b0, v, 3'b0};  endfunction

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  logic        rdy_q[$];
  logic [6:0]  op_q[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom);
  endfunction

  task automatic push_cycle(input logic rdy, input logic [6:0] op, input logic [16:0] e);
    rdy_q.push_back(rdy);
    op_q.push_back(op);
    exp_q.push_back(e);
  endtask

  task automatic clear_plan();
    rdy_q.delete();
    op_q.delete();
    exp_q.delete();
  endtask

  // ---------------- reference model ----------------
  // Expands one instruction into its cycle-by-cycle expected behaviour.
  task automatic plan_instr(input logic [6:0] op, input int fwait, input int mwait);
    string kind;
    case (op)
      7'b0110011: kind = "R";
      7'b0010011: kind = "I";
      7'b0000011: kind = "LOAD";
      7'b0100011: kind = "STORE";
      7'b1100011: kind = "BRANCH";
      7'b1101111: kind = "JAL";
      7'b1100111: kind = "JALR";
      default:    kind = "ILLEGAL";
    endcase
    for (int i = 0; i < fwait; i++)
      push_cycle(1'b0, rnd_op(), B_RD | f_asb(2'b01));
    push_cycle(1'b1, rnd_op(), B_RD | B_IRW | B_PCW | f_asb(2'b01));
    if (kind == "ILLEGAL") begin
      push_cycle(rnd_bit(), op, B_ILL);
      return;
    end
    push_cycle(rnd_bit(), op, '0);
    // opcode after DECODE is garbage: the latched class must carry the instruction
    if (kind == "R") begin
      push_cycle(rnd_bit(), rnd_op(), B_ASA | f_asb(2'b00) | f_aop(2'b10));
      push_cycle(rnd_bit(), rnd_op(), B_RW | f_m2r(2'b00) | B_DONE);
    end else if (kind == "I") begin
      push_cycle(rnd_bit(), rnd_op(), B_ASA | f_asb(2'b10) | f_aop(2'b11));
      push_cycle(rnd_bit(), rnd_op(), B_RW | f_m2r(2'b00) | B_DONE);
    end else if (kind == "LOAD" || kind == "STORE") begin
      push_cycle(rnd_bit(), rnd_op(), B_ASA | f_asb(2'b10) | f_aop(2'b00));
      for (int i = 0; i < mwait; i++)
        push_cycle(1'b0, rnd_op(), (kind == "LOAD") ? B_RD : B_WR);
      if (kind == "LOAD") begin
        push_cycle(1'b1, rnd_op(), B_RD);
        push_cycle(rnd_bit(), rnd_op(), B_RW | f_m2r(2'b01) | B_DONE);
      end else begin
        push_cycle(1'b1, rnd_op(), B_WR | B_DONE);
      end
    end else if (kind == "BRANCH") begin
      push_cycle(rnd_bit(), rnd_op(),
                 B_ASA | f_asb(2'b00) | f_aop(2'b01) | B_PCC | f_pcs(2'b01) | B_DONE);
    end else if (kind == "JAL") begin
      push_cycle(rnd_bit(), rnd_op(), B_RW | f_m2r(2'b10) | B_PCW | f_pcs(2'b01) | B_DONE);
    end else begin
      push_cycle(rnd_bit(), rnd_op(), B_RW | f_m2r(2'b10) | B_PCW | f_pcs(2'b10) |
                 B_ASA | f_asb(2'b10) | f_aop(2'b00) | B_DONE);
    end
  endtask

  // ---------------- driver ----------------
  // Entered and left at posedge + 1; samples on the falling edge.
  task automatic run_plan(input string name, input int n_max);
    int n = 0;
    logic [16:0] e;
    while (exp_q.size() > 0 && n < n_max) begin
      mem_ready = rdy_q.pop_front();
      opcode    = op_q.pop_front();
      e         = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got=%05h exp=%05h", name, n + 1, got, e);
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (got !== 17'h0) begin
      errors++;
      $display("FAIL %s: outputs got=%05h exp=00000", name, got);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; opcode = 7'h00; mem_ready = 1'b0;
    #2;
    check_zero("reset_initial");
    mem_ready = 1'b1;
    @(negedge clk);
    check_zero("reset_ready_high");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_r_type();
    plan_instr(7'b0110011, 0, 0);
    run_plan("r_type", 100);
  endtask

  task automatic test_load_wait();
    plan_instr(7'b0000011, 0, 3);
    run_plan("load_wait3", 100);
  endtask

  task automatic test_store();
    plan_instr(7'b0100011, 0, 0);
    run_plan("store", 100);
  endtask

  task automatic test_branch_jalr();
    plan_instr(7'b1100011, 0, 0);
    plan_instr(7'b1100111, 0, 0);
    run_plan("branch_jalr", 100);
  endtask

  task automatic test_illegal();
    plan_instr(7'b1111111, 0, 0);
    plan_instr(7'b0010011, 0, 0);
    run_plan("illegal_then_i", 100);
  endtask

  task automatic test_reset_mid_store();
    plan_instr(7'b0100011, 1, 6);
    run_plan("store_before_reset", 6);
    clear_plan();
    reset = 1'b1;
    #1;
    check_zero("reset_mid_mem_immediate");
    for (int i = 0; i < 2; i++) begin
      mem_ready = rnd_bit();
      @(negedge clk);
      check_zero("reset_mid_mem_hold");
      @(posedge clk); #1;
    end
    reset = 1'b0;
    plan_instr(7'b0110011, 0, 0);
    run_plan("after_reset_r", 100);
  endtask

  task automatic test_random();
    logic [6:0] ops [0:7];
    logic [6:0] op;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    ops[6] = 7'b1100111; ops[7] = 7'b0000000;
    for (int k = 0; k < 60; k++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == 7'b0000000) op = rnd_op();
      plan_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    run_plan("random", 100000);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_r_type();
    test_load_wait();
    test_store();
    test_branch_jalr();
    test_illegal();
    test_reset_mid_store();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
